pipe_sequencer: RTL and testbench
=================================

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 Parameter TICK_CYCLES, default 12_500_000, Clock cycles per scroll tick.
REQ-002 Parameter GAP_COLS, default 8, number of scroll ticks from one pipe insertion to the next (1..16).
REQ-003 Parameter BIRD_COL, default 2, field column occupied by the bird (0..15).
REQ-004 Clock  in  1  system clock; all state updates on its posedge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  level, sampled each cycle; begins play from IDLE and acknowledges game over from OVER.
REQ-007 bird_row  in  4  current bird row, 0 = bottom.
REQ-008 gen_col  in  16  pipe column from the pipe generator; bit r = row r solid; valid only while gen_valid=1.
REQ-009 gen_valid  in  1  generator holds a column for this request.
REQ-010 gen_req  out  1  one-cycle pulse requesting one new pipe column.
REQ-011 field  out  256  playfield; bit c*16+r = column c, row r; column 0 leftmost.
REQ-012 score  out  8  pipes cleared, saturating.
REQ-013 playing  out  1  high in PLAY and FETCH.
REQ-014 game_over  out  1  high in OVER.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY, FETCH and OVER, held in one registered state variable.
REQ-016 IDLE: field, score, tick_cnt and space_cnt held at 0; start=1 -> PLAY on the next cycle.
REQ-017 PLAY: tick_cnt increments each cycle; at tick_cnt=TICK_CYCLES-1 it wraps to 0, and this cycle is a tick.
REQ-018 On a tick with space_cnt=0: gen_req=1 for exactly that cycle, field unchanged, next state FETCH.
REQ-019 On a tick with space_cnt!=0: field shifts left one column, column 15 <= 16'h0000, space_cnt decrements.
REQ-020 FETCH: tick_cnt frozen, gen_req=0; the block waits indefinitely until gen_valid=1.
REQ-021 In the FETCH cycle with gen_valid=1: field shifts left, column 15 <= gen_col, space_cnt <= GAP_COLS-1, next state PLAY.
REQ-022 Each left shift SHALL move column c+1 into column c for c=0..14; column 0 is discarded.
REQ-023 Score: on every shift, if the discarded column 0 is nonzero, score increments by 1 and saturates at 255.
REQ-024 Collision: in PLAY or FETCH, if field[BIRD_COL*16+bird_row]=1 (registered field), next state is OVER.
REQ-025 Collision SHALL take priority over a tick or a gen_valid accept in the same cycle; field and score stay frozen that cycle.
REQ-026 OVER: field and score are frozen; start=1 -> IDLE (clears per REQ-016); start has no effect in PLAY or FETCH.
REQ-027 gen_col SHALL be ignored outside the FETCH accept cycle; gen_valid in any other state has no effect.
REQ-028 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-029 RST=1 SHALL, at the next posedge, force IDLE and clear field, score, tick_cnt, space_cnt and gen_req to 0 (playing=0, game_over=0), from any state including FETCH and OVER; RST overrides all other inputs.

Verification (bench: TICK_CYCLES=4, GAP_COLS=3, BIRD_COL=2)
REQ-030 Reset: RST high 2 cycles from any state -> field=0, score=0, gen_req=0, playing=0, game_over=0.
REQ-031 Start/fetch: start 1 cycle, gen_valid=1, gen_col=16'hF03F -> gen_req pulses on the 4th PLAY cycle; one cycle later field[255:240]=16'hF03F; second gen_req after 3 further ticks.
REQ-032 Stall: gen_valid=0 for 10 cycles after gen_req -> single gen_req pulse, field unchanged, tick_cnt frozen; gen_valid=1 -> insert, then PLAY.
REQ-033 Collision: bird_row=0 with gen_col=16'hF03F -> game_over=1 the cycle after the pipe reaches column 2; field frozen; start -> IDLE with field=0.
REQ-034 Clear: bird_row=6 (in gap) -> no game over; score increments to 1 on the shift that discards the pipe from column 0; forced 300 clears -> score=255.
REQ-035 Mid-operation reset: RST asserted in FETCH with gen_valid=1 the same cycle -> IDLE, no insertion, field=0, score=0.

Source files
------------

// File: rtl/pipe_sequencer_if.sv
// Signal bundle between the pipe sequencer and its surroundings: control inputs,
// the pipe-generator handshake and the playfield/score status outputs.
interface pipe_sequencer_if;
   logic         start;
   logic [3:0]   bird_row;
   logic [15:0]  gen_col;
   logic         gen_valid;
   logic         gen_req;
   logic [255:0] field;
   logic [7:0]   score;
   logic         playing;
   logic         game_over;

   modport master (
      output start, bird_row, gen_col, gen_valid,
      input  gen_req, field, score, playing, game_over
   );

   modport slave (
      input  start, bird_row, gen_col, gen_valid,
      output gen_req, field, score, playing, game_over
   );
endinterface

// File: rtl/pipe_sequencer.sv
// Scrolling pipe playfield sequencer: scrolls a 16x16 field once per tick, requests
// a new pipe column every GAP_COLS ticks, scores cleared pipes and detects collisions.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | field/score/counters cleared, waiting for start
// S_PLAY  | tick counter running, field scrolls on each tick
// S_FETCH | tick frozen, waiting for the generator to supply a column
// S_OVER  | bird hit a pipe, field and score frozen until start
module pipe_sequencer #(
   parameter int TICK_CYCLES = 12_500_000,
   parameter int GAP_COLS    = 8,
   parameter int BIRD_COL    = 2
) (
   input logic              Clock,
   input logic              RST,
   pipe_sequencer_if.slave  bus
);

   localparam int             TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [3:0]     GAP_LAST  = 4'(GAP_COLS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_FETCH = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [255:0]    field_q, field_d;
   logic [7:0]      score_q, score_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [3:0]      space_q, space_d;
   logic            gen_req_q, gen_req_d;

   logic [15:0]     bird_col;
   logic            hit;
   logic            tick;
   logic [7:0]      score_bump;

   assign bird_col   = field_q[BIRD_COL*16 +: 16];
   assign hit        = bird_col[bus.bird_row];
   assign tick       = (tick_q == TICK_LAST);
   // Score reflects the column about to fall off the left edge on a shift.
   assign score_bump = ((|field_q[15:0]) && (score_q != 8'hFF)) ? score_q + 8'd1 : score_q;

   always_ff @(posedge Clock) begin
      if (RST) begin
         state_q   <= S_IDLE;
         field_q   <= '0;
         score_q   <= '0;
         tick_q    <= '0;
         space_q   <= '0;
         gen_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_d;
         score_q   <= score_d;
         tick_q    <= tick_d;
         space_q   <= space_d;
         gen_req_q <= gen_req_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      field_d   = field_q;
      score_d   = score_q;
      tick_d    = tick_q;
      space_d   = space_q;
      gen_req_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            field_d = '0;
            score_d = '0;
            tick_d  = '0;
            space_d = '0;
            if (bus.start) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (hit) begin
               state_d = S_OVER;
            end else if (tick) begin
               tick_d = '0;
               if (space_q == 4'd0) begin
                  gen_req_d = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  field_d = {16'h0000, field_q[255:16]};
                  score_d = score_bump;
                  space_d = space_q - 4'd1;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         S_FETCH: begin
            if (hit) begin
               state_d = S_OVER;
            end else if (bus.gen_valid) begin
               field_d = {bus.gen_col, field_q[255:16]};
               score_d = score_bump;
               space_d = GAP_LAST;
               state_d = S_PLAY;
            end
         end
         S_OVER: begin
            // Leaving OVER clears immediately so IDLE is never seen with a stale field.
            if (bus.start) begin
               state_d = S_IDLE;
               field_d = '0;
               score_d = '0;
               tick_d  = '0;
               space_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.gen_req   = gen_req_q;
   assign bus.field     = field_q;
   assign bus.score     = score_q;
   assign bus.playing   = (state_q == S_PLAY) || (state_q == S_FETCH);
   assign bus.game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: directed scenarios plus randomized play, checked against
// a column-array game model kept in the bench.
module tb_pipe_sequencer;

   localparam int TICK = 4;
   localparam int GAP  = 3;
   localparam int BIRD = 2;

   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_WAIT = 2;
   localparam int M_OVER = 3;

   logic Clock = 1'b0;
   logic RST   = 1'b1;

   pipe_sequencer_if bus ();

   pipe_sequencer #(.TICK_CYCLES(TICK), .GAP_COLS(GAP), .BIRD_COL(BIRD)) dut (
      .Clock (Clock),
      .RST   (RST),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   int checks   = 0;
   int failures = 0;

   // Game model: columns as an array, plain integer counters.
   logic [15:0] m_col [16];
   int          m_score;
   int          m_clears;
   int          m_tick;
   int          m_space;
   int          m_mode;
   bit          m_gen_req;

   function automatic logic [255:0] m_field();
      logic [255:0] f;
      for (int c = 0; c < 16; c++) f[c*16 +: 16] = m_col[c];
      return f;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < 16; c++) m_col[c] = 16'h0000;
      m_score = 0;
      m_tick  = 0;
      m_space = 0;
   endtask

   task automatic model_shift(input logic [15:0] newcol);
      if (m_col[0] != 16'h0000) begin
         m_clears++;
         if (m_score < 255) m_score++;
      end
      for (int c = 0; c < 15; c++) m_col[c] = m_col[c+1];
      m_col[15] = newcol;
   endtask

   task automatic model_step();
      bit h;
      if (RST) begin
         model_clear();
         m_mode    = M_IDLE;
         m_gen_req = 1'b0;
      end else begin
         m_gen_req = 1'b0;
         h = m_col[BIRD][bus.bird_row];
         case (m_mode)
            M_IDLE: begin
               model_clear();
               if (bus.start) m_mode = M_PLAY;
            end
            M_PLAY: begin
               if (h) m_mode = M_OVER;
               else begin
                  m_tick++;
                  if (m_tick == TICK) begin
                     m_tick = 0;
                     if (m_space == 0) begin
                        m_gen_req = 1'b1;
                        m_mode    = M_WAIT;
                     end else begin
                        model_shift(16'h0000);
                        m_space--;
                     end
                  end
               end
            end
            M_WAIT: begin
               if (h) m_mode = M_OVER;
               else if (bus.gen_valid) begin
                  model_shift(bus.gen_col);
                  m_space = GAP - 1;
                  m_mode  = M_PLAY;
               end
            end
            default: begin
               if (bus.start) begin
                  m_mode = M_IDLE;
                  model_clear();
               end
            end
         endcase
      end
   endtask

   task automatic tick_cycle();
      @(posedge Clock);
      model_step();
      @(negedge Clock);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (2) tick_cycle();
      RST = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick_cycle();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.gen_valid = 1'b0; bus.gen_col = 16'h0; bus.bird_row = 4'd0;
      RST = 1'b1;
      repeat (2) tick_cycle();
      checks++; if (bus.field !== 256'h0) begin failures++; $display("FAIL reset_field got=%h exp=0", bus.field); end
      checks++; if (bus.score !== 8'h00) begin failures++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
      checks++; if (bus.gen_req !== 1'b0) begin failures++; $display("FAIL reset_gen_req got=%b exp=0", bus.gen_req); end
      checks++; if (bus.playing !== 1'b0) begin failures++; $display("FAIL reset_playing got=%b exp=0", bus.playing); end
      checks++; if (bus.game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over got=%b exp=0", bus.game_over); end
      RST = 1'b0;
   endtask

   task automatic test_start_fetch();
      int n;
      do_reset();
      bus.bird_row = 4'd6; bus.gen_valid = 1'b1; bus.gen_col = 16'hF03F;
      pulse_start();
      n = 0;
      while (bus.gen_req !== 1'b1 && n < 20) begin tick_cycle(); n++; end
      checks++; if (n != 4) begin failures++; $display("FAIL first_gen_req_latency got=%0d exp=4", n); end
      checks++; if (bus.playing !== 1'b1) begin failures++; $display("FAIL fetch_playing got=%b exp=1", bus.playing); end
      tick_cycle();
      checks++; if (bus.gen_req !== 1'b0) begin failures++; $display("FAIL gen_req_one_cycle got=%b exp=0", bus.gen_req); end
      checks++; if (bus.field[255:240] !== 16'hF03F) begin failures++; $display("FAIL insert_col15 got=%h exp=f03f", bus.field[255:240]); end
      checks++; if (bus.field !== m_field()) begin failures++; $display("FAIL insert_field got=%h exp=%h", bus.field, m_field()); end
      n = 0;
      do begin tick_cycle(); n++; end while (bus.gen_req !== 1'b1 && n < 40);
      checks++; if (n != 12) begin failures++; $display("FAIL second_gen_req_latency got=%0d exp=12", n); end
      checks++; if (bus.field !== m_field()) begin failures++; $display("FAIL second_req_field got=%h exp=%h", bus.field, m_field()); end
   endtask

   task automatic test_stall();
      int n, pulses;
      do_reset();
      bus.bird_row = 4'd6; bus.gen_valid = 1'b0; bus.gen_col = 16'hF03F;
      pulse_start();
      n = 0;
      while (bus.gen_req !== 1'b1 && n < 20) begin tick_cycle(); n++; end
      pulses = (bus.gen_req === 1'b1) ? 1 : 0;
      repeat (10) begin
         tick_cycle();
         if (bus.gen_req === 1'b1) pulses++;
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL stall_gen_req_pulses got=%0d exp=1", pulses); end
      checks++; if (bus.field !== 256'h0) begin failures++; $display("FAIL stall_field got=%h exp=0", bus.field); end
      checks++; if (bus.playing !== 1'b1) begin failures++; $display("FAIL stall_playing got=%b exp=1", bus.playing); end
      bus.gen_valid = 1'b1;
      tick_cycle();
      bus.gen_valid = 1'b0;
      checks++; if (bus.field[255:240] !== 16'hF03F) begin failures++; $display("FAIL stall_insert got=%h exp=f03f", bus.field[255:240]); end
      n = 0;
      do begin tick_cycle(); n++; end while (bus.gen_req !== 1'b1 && n < 40);
      checks++; if (n != 12) begin failures++; $display("FAIL stall_tick_frozen got=%0d exp=12", n); end
   endtask

   task automatic test_collision();
      int n, t_arrive, t_over;
      logic [255:0] f;
      logic [7:0]   s;
      do_reset();
      bus.bird_row = 4'd0; bus.gen_valid = 1'b1; bus.gen_col = 16'hF03F;
      pulse_start();
      n = 0; t_arrive = -1; t_over = -1;
      while (bus.game_over !== 1'b1 && n < 400) begin
         tick_cycle(); n++;
         if (t_arrive < 0 && bus.field[47:32] != 16'h0) t_arrive = n;
      end
      t_over = n;
      checks++; if (bus.game_over !== 1'b1) begin failures++; $display("FAIL collision_game_over got=%b exp=1", bus.game_over); end
      checks++; if (t_over != t_arrive + 1) begin failures++; $display("FAIL collision_timing got=%0d exp=%0d", t_over, t_arrive + 1); end
      checks++; if (bus.field !== m_field()) begin failures++; $display("FAIL collision_field got=%h exp=%h", bus.field, m_field()); end
      f = bus.field; s = bus.score;
      repeat (6) tick_cycle();
      checks++; if (bus.field !== f) begin failures++; $display("FAIL over_field_frozen got=%h exp=%h", bus.field, f); end
      checks++; if (bus.score !== s) begin failures++; $display("FAIL over_score_frozen got=%0d exp=%0d", bus.score, s); end
      checks++; if (bus.game_over !== 1'b1 || bus.playing !== 1'b0) begin failures++; $display("FAIL over_hold got=%b%b exp=10", bus.game_over, bus.playing); end
      pulse_start();
      checks++; if (bus.game_over !== 1'b0 || bus.playing !== 1'b0) begin failures++; $display("FAIL over_to_idle got=%b%b exp=00", bus.game_over, bus.playing); end
      checks++; if (bus.field !== 256'h0) begin failures++; $display("FAIL idle_field_clear got=%h exp=0", bus.field); end
   endtask

   task automatic test_clear();
      int n;
      bit any_over;
      logic [15:0] prev_col0;
      do_reset();
      bus.bird_row = 4'd6; bus.gen_valid = 1'b1; bus.gen_col = 16'hF03F;
      m_clears = 0;
      pulse_start();
      n = 0; prev_col0 = 16'h0;
      while (bus.score == 8'd0 && n < 400) begin
         prev_col0 = bus.field[15:0];
         tick_cycle(); n++;
      end
      checks++; if (bus.score !== 8'd1) begin failures++; $display("FAIL first_clear_score got=%0d exp=1", bus.score); end
      checks++; if (prev_col0 !== 16'hF03F) begin failures++; $display("FAIL first_clear_col0 got=%h exp=f03f", prev_col0); end
      n = 0; any_over = 1'b0;
      while (m_clears < 300 && n < 8000) begin
         tick_cycle(); n++;
         if (bus.game_over === 1'b1) any_over = 1'b1;
      end
      checks++; if (any_over) begin failures++; $display("FAIL clear_no_over got=1 exp=0"); end
      checks++; if (m_clears < 300) begin failures++; $display("FAIL clear_count_timeout got=%0d exp=300", m_clears); end
      checks++; if (bus.score !== 8'd255) begin failures++; $display("FAIL score_saturate got=%0d exp=255", bus.score); end
   endtask

   task automatic test_mid_reset();
      int n;
      do_reset();
      bus.bird_row = 4'd6; bus.gen_valid = 1'b0; bus.gen_col = 16'hFFFF;
      pulse_start();
      n = 0;
      while (bus.gen_req !== 1'b1 && n < 20) begin tick_cycle(); n++; end
      bus.gen_valid = 1'b1;
      RST = 1'b1;
      tick_cycle();
      RST = 1'b0;
      checks++; if (bus.playing !== 1'b0 || bus.game_over !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b%b exp=00", bus.playing, bus.game_over); end
      checks++; if (bus.field !== 256'h0) begin failures++; $display("FAIL midrst_field got=%h exp=0", bus.field); end
      checks++; if (bus.score !== 8'd0 || bus.gen_req !== 1'b0) begin failures++; $display("FAIL midrst_score_req got=%0d/%b exp=0/0", bus.score, bus.gen_req); end
      tick_cycle();
      checks++; if (bus.field !== 256'h0 || bus.playing !== 1'b0) begin failures++; $display("FAIL midrst_idle_hold got=%b exp=0", bus.playing); end
      bus.gen_valid = 1'b0;
   endtask

   task automatic test_random();
      bit exp_play;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         RST           = ($urandom_range(0, 249) == 0);
         bus.start     = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) bus.bird_row = 4'($urandom_range(0, 15));
         bus.gen_valid = ($urandom_range(0, 2) == 0);
         bus.gen_col   = ($urandom_range(0, 1) == 0) ? 16'hF03F : 16'($urandom);
         tick_cycle();
         exp_play = (m_mode == M_PLAY) || (m_mode == M_WAIT);
         checks++; if (bus.field !== m_field()) begin failures++; $display("FAIL rand_field i=%0d got=%h exp=%h", i, bus.field, m_field()); end
         checks++; if (bus.score !== 8'(m_score)) begin failures++; $display("FAIL rand_score i=%0d got=%0d exp=%0d", i, bus.score, m_score); end
         checks++; if (bus.gen_req !== m_gen_req) begin failures++; $display("FAIL rand_gen_req i=%0d got=%b exp=%b", i, bus.gen_req, m_gen_req); end
         checks++; if (bus.playing !== exp_play) begin failures++; $display("FAIL rand_playing i=%0d got=%b exp=%b", i, bus.playing, exp_play); end
         checks++; if (bus.game_over !== (m_mode == M_OVER)) begin failures++; $display("FAIL rand_game_over i=%0d got=%b exp=%b", i, bus.game_over, (m_mode == M_OVER)); end
      end
      RST = 1'b0; bus.start = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0; bus.bird_row = 4'd0; bus.gen_col = 16'h0; bus.gen_valid = 1'b0;
      m_clears = 0; m_mode = M_IDLE; m_gen_req = 1'b0;
      model_clear();
      @(negedge Clock);
      test_reset();
      test_start_fetch();
      test_stall();
      test_collision();
      test_clear();
      test_mid_reset();
      test_random();
      test_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
